microc_stack: RTL and testbench

- Parametrised successor to the single-cycle microcontroller datapath, with generalised data and PC widths.
- Contains: PC, 16-entry register file, ALU, zero flag, and a hardware return-address stack for subroutine call/return.
- Instruction memory is external. The datapath drives `pc` and receives `instr` combinationally in the same cycle.
- Driven cycle-by-cycle by an external control unit that decodes `opcode`.

---
 rtl/microc_stack.sv | 130 +++++++++++++
 tb/tb_microc_stack.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath: PC, 16-entry register file, ALU,
// zero flag and a hardware return-address stack for call/return.
module microc_stack #(
    parameter  int DW          = 8,
    parameter  int AW          = 10,
    parameter  int STACK_DEPTH = 8,
    localparam int IW          = 6 + ((AW > DW + 4) ? AW : DW + 4),
    localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic          s_inc,
    input  logic          s_inm,
    input  logic          we,
    input  logic          wez,
    input  logic [2:0]    alu_op,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] pc,
    output logic [5:0]    opcode,
    output logic          zero,
    output logic [CW-1:0] stk_count,
    output logic          stk_ovf,
    output logic          stk_unf,
    output logic          stk_err
);

    localparam int            SW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

    logic signed [DW-1:0] regs [16];
    logic        [AW-1:0] stack [STACK_DEPTH];

    logic        [3:0]    rs1, rs2, rd;
    logic signed [DW-1:0] op_a, op_b, result;
    logic        [AW-1:0] pc_inc, pc_next;
    logic        [SW-1:0] push_idx, top_idx;
    logic                 push, pop, set_ovf, set_unf, set_err;

    function automatic logic signed [DW-1:0] alu(input logic [2:0]           op,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        case (op)
            3'b000:  alu = a;
            3'b001:  alu = ~a;
            3'b010:  alu = a + b;
            3'b011:  alu = a - b;
            3'b100:  alu = a & b;
            3'b101:  alu = a | b;
            3'b110:  alu = -a;
            default: alu = -b;
        endcase
    endfunction

    assign opcode = instr[IW-1:IW-6];
    assign rd     = instr[3:0];
    assign rs2    = instr[7:4];
    assign rs1    = s_inm ? instr[3:0] : instr[11:8];

    // R0 is hard-wired to zero on the read side; its storage is never written.
    assign op_a   = (rs1 == 4'd0) ? '0 : regs[rs1];
    assign op_b   = s_inm ? instr[DW+3:4] : ((rs2 == 4'd0) ? '0 : regs[rs2]);
    assign result = alu(alu_op, op_a, op_b);

    assign pc_inc   = pc + AW'(1);
    assign push_idx = stk_count[SW-1:0];
    assign top_idx  = push_idx - SW'(1);

    always_comb begin
        pc_next = s_inc ? pc_inc : instr[AW-1:0];
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_err = 1'b0;
        if (call && ret) begin
            set_err = 1'b1;
        end else if (call) begin
            if (stk_count < DEPTH_C) begin
                push    = 1'b1;
                pc_next = instr[AW-1:0];
            end else begin
                set_ovf = 1'b1;
                pc_next = pc_inc;
            end
        end else if (ret) begin
            if (stk_count != '0) begin
                pop     = 1'b1;
                pc_next = stack[top_idx];
            end else begin
                set_unf = 1'b1;
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            zero      <= 1'b0;
            stk_count <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
            stk_err   <= 1'b0;
        end else begin
            pc <= pc_next;
            if (wez) zero <= (result == '0);
            if (push) stk_count <= stk_count + CW'(1);
            else if (pop) stk_count <= stk_count - CW'(1);
            if (set_ovf) stk_ovf <= 1'b1;
            if (set_unf) stk_unf <= 1'b1;
            if (set_err) stk_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we && rd != 4'd0) begin
            regs[rd] <= result;
        end
    end

    // Entries above stk_count are don't-care, so the stack needs no reset.
    always_ff @(posedge clk) begin
        if (push) stack[push_idx] <= pc_inc;
    end

endmodule

// File: tb/tb_microc_stack.sv
// Bench for microc_stack: a default instance and a small one (AW=4, depth 2),
// both compared every cycle against a queue-based reference model.
module tb_microc_stack;

    localparam int IW = 18;

    logic          clk;
    logic          reset;
    logic [IW-1:0] instr  [2];
    logic          s_inc  [2];
    logic          s_inm  [2];
    logic          we     [2];
    logic          wez    [2];
    logic [2:0]    alu_op [2];
    logic          call   [2];
    logic          ret    [2];

    logic [9:0] pc0;
    logic [3:0] pc1;
    logic [5:0] opc0, opc1;
    logic       zero0, zero1;
    logic [3:0] cnt0;
    logic [1:0] cnt1;
    logic       ovf0, ovf1, unf0, unf1, err0, err1;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_pc   [2];
    int m_zero [2];
    int m_ovf  [2];
    int m_unf  [2];
    int m_err  [2];
    int m_reg  [2][16];
    int m_stk  [2][$];

    microc_stack #(.DW(8), .AW(10), .STACK_DEPTH(8)) u_big (
        .clk(clk), .reset(reset), .instr(instr[0]), .s_inc(s_inc[0]), .s_inm(s_inm[0]),
        .we(we[0]), .wez(wez[0]), .alu_op(alu_op[0]), .call(call[0]), .ret(ret[0]),
        .pc(pc0), .opcode(opc0), .zero(zero0), .stk_count(cnt0),
        .stk_ovf(ovf0), .stk_unf(unf0), .stk_err(err0)
    );

    microc_stack #(.DW(8), .AW(4), .STACK_DEPTH(2)) u_small (
        .clk(clk), .reset(reset), .instr(instr[1]), .s_inc(s_inc[1]), .s_inm(s_inm[1]),
        .we(we[1]), .wez(wez[1]), .alu_op(alu_op[1]), .call(call[1]), .ret(ret[1]),
        .pc(pc1), .opcode(opc1), .zero(zero1), .stk_count(cnt1),
        .stk_ovf(ovf1), .stk_unf(unf1), .stk_err(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int imm_ins(input int rd, input int imm);
        return ((imm & 255) << 4) | (rd & 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_zero[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_err[i] = 0;
            m_stk[i].delete();
            for (int r = 0; r < 16; r++) m_reg[i][r] = 0;
        end
    endtask

    task automatic m_step(input int i);
        int aw, depth, mask, x, rd, rs1, rs2, a, b, res, pinc, tgt, npc;
        aw    = (i == 0) ? 10 : 4;
        depth = (i == 0) ? 8 : 2;
        mask  = (1 << aw) - 1;
        x     = int'(instr[i]);
        rd    = x & 15;
        rs2   = (x >> 4) & 15;
        rs1   = s_inm[i] ? rd : ((x >> 8) & 15);
        a     = m_reg[i][rs1];
        b     = s_inm[i] ? ((x >> 4) & 255) : m_reg[i][rs2];
        case (int'(alu_op[i]))
            0: res = a;
            1: res = ~a;
            2: res = a + b;
            3: res = a - b;
            4: res = a & b;
            5: res = a | b;
            6: res = -a;
            default: res = -b;
        endcase
        res  = res & 255;
        pinc = (m_pc[i] + 1) & mask;
        tgt  = x & mask;
        npc  = s_inc[i] ? pinc : tgt;
        if (call[i] && ret[i]) begin
            m_err[i] = 1;
        end else if (call[i]) begin
            if (m_stk[i].size() < depth) begin
                m_stk[i].push_back(pinc);
                npc = tgt;
            end else begin
                npc = pinc;
                m_ovf[i] = 1;
            end
        end else if (ret[i]) begin
            if (m_stk[i].size() > 0) npc = m_stk[i].pop_back();
            else begin
                npc = pinc;
                m_unf[i] = 1;
            end
        end
        m_pc[i] = npc;
        if (we[i] && rd != 0) m_reg[i][rd] = res;
        if (wez[i]) m_zero[i] = (res == 0) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("pc0",   32'(pc0),   32'(m_pc[0]));
        chk("opc0",  32'(opc0),  32'(instr[0][17:12]));
        chk("zero0", 32'(zero0), 32'(m_zero[0]));
        chk("cnt0",  32'(cnt0),  32'(m_stk[0].size()));
        chk("ovf0",  32'(ovf0),  32'(m_ovf[0]));
        chk("unf0",  32'(unf0),  32'(m_unf[0]));
        chk("err0",  32'(err0),  32'(m_err[0]));
        chk("pc1",   32'(pc1),   32'(m_pc[1]));
        chk("opc1",  32'(opc1),  32'(instr[1][17:12]));
        chk("zero1", 32'(zero1), 32'(m_zero[1]));
        chk("cnt1",  32'(cnt1),  32'(m_stk[1].size()));
        chk("ovf1",  32'(ovf1),  32'(m_ovf[1]));
        chk("unf1",  32'(unf1),  32'(m_unf[1]));
        chk("err1",  32'(err1),  32'(m_err[1]));
    endtask

    task automatic set_op(input int i, input int ins, input bit inc, input bit inm,
                          input bit w, input bit wz, input int op, input bit c, input bit r);
        instr[i]  = IW'(ins);
        s_inc[i]  = inc;
        s_inm[i]  = inm;
        we[i]     = w;
        wez[i]    = wz;
        alu_op[i] = 3'(op);
        call[i]   = c;
        ret[i]    = r;
    endtask

    // hold the PC by jumping to itself, with no other side effects
    task automatic set_idle(input int i);
        set_op(i, m_pc[i], 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_reset();
        check_all();
        #2;
        reset = 1'b1;
        set_idle(0);
        set_idle(1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) set_op(i, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("rst_pc", 32'(pc0), 32'd0);
        #21;
        reset = 1'b1;

        // sequential walk
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("walk_pc", 32'(pc0), 32'(k));
        end
        chk("walk_cnt", 32'(cnt0), 32'd0);
        set_idle(1);

        // immediate path
        set_op(0, imm_ins(1, 8'h05), 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        tick();
        set_op(0, imm_ins(1, 8'h05), 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        tick();
        chk("sub_zero", 32'(zero0), 32'd1);
        set_op(0, imm_ins(0, 8'h33), 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        tick();
        chk("r0_wr_zero", 32'(zero0), 32'd0);
        set_op(0, imm_ins(0, 8'h00), 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        tick();
        chk("r0_reads0", 32'(zero0), 32'd1);

        // nested calls
        set_op(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        chk("goto3", 32'(pc0), 32'h3);
        set_op(0, 'h40, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("call1_pc", 32'(pc0), 32'h40);
        chk("call1_cnt", 32'(cnt0), 32'd1);
        set_op(0, 'h80, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("call2_pc", 32'(pc0), 32'h80);
        chk("call2_cnt", 32'(cnt0), 32'd2);
        set_op(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("ret1_pc", 32'(pc0), 32'h41);
        tick();
        chk("ret2_pc", 32'(pc0), 32'h4);
        chk("ret2_cnt", 32'(cnt0), 32'd0);
        chk("nest_flags", 32'({ovf0, unf0, err0}), 32'd0);
        set_idle(0);

        // overflow on the depth-2 instance
        set_op(1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        set_op(1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        set_op(1, 12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("ovf_pc", 32'(pc1), 32'd10);
        chk("ovf_flag", 32'(ovf1), 32'd1);
        chk("ovf_cnt", 32'(cnt1), 32'd2);

        // underflow in a fresh run
        do_reset();
        set_op(1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("unf_pc", 32'(pc1), 32'd1);
        chk("unf_flag", 32'(unf1), 32'd1);

        // PC wrap with AW=4
        set_op(1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        set_op(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        chk("wrap_pc", 32'(pc1), 32'd0);
        set_op(1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        set_op(1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("wcall_pc", 32'(pc1), 32'd3);
        set_op(1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("wret_pc", 32'(pc1), 32'd0);
        set_op(1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        chk("both_err", 32'(err1), 32'd1);
        chk("both_cnt", 32'(cnt1), 32'd0);
        chk("both_pc", 32'(pc1), 32'd1);

        // randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                set_op(i, int'($urandom & 32'h3FFFF), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            end
            tick();
        end

        // asynchronous reset mid-cycle during a call with a pending write
        set_op(0, imm_ins(5, 8'h21), 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        set_idle(1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_pc", 32'(pc0), 32'd0);
        chk("arst_cnt", 32'(cnt0), 32'd0);
        chk("arst_zero", 32'(zero0), 32'd0);
        chk("arst_flags", 32'({ovf0, unf0, err0, ovf1, unf1, err1}), 32'd0);
        m_reset();
        check_all();
        #2;
        reset = 1'b1;
        set_op(0, imm_ins(5, 8'h00), 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        set_idle(1);
        tick();
        chk("arst_r5", 32'(zero0), 32'd1);
        chk("arst_pc1", 32'(pc0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
